// File: rtl/rf_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// the register-count derivation used by every file of the block.
package rf_pkg;

  localparam int unsigned RF_DW   = 8;
  localparam int unsigned RF_AW   = 3;
  localparam int unsigned RF_NREG = 2 ** RF_AW;

  function automatic int unsigned nreg(input int unsigned aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle of the register file: two write ports, two read ports and the
// write-tracking status outputs.
interface register_file_mp_if
  import rf_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW
);
  localparam int unsigned NREG = nreg(AW);

  logic            WEN0;
  logic [AW-1:0]   RW0;
  logic [DW-1:0]   busW0;
  logic            WEN1;
  logic [AW-1:0]   RW1;
  logic [DW-1:0]   busW1;
  logic [AW-1:0]   RX;
  logic [AW-1:0]   RY;
  logic [DW-1:0]   busX;
  logic [DW-1:0]   busY;
  logic [NREG-1:0] wr_mask;
  logic            wr_conflict;

  modport master (
    output WEN0, RW0, busW0, WEN1, RW1, busW1, RX, RY,
    input  busX, busY, wr_mask, wr_conflict
  );

  modport slave (
    input  WEN0, RW0, busW0, WEN1, RW1, busW1, RX, RY,
    output busX, busY, wr_mask, wr_conflict
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: stored value, optionally overridden by a
// same-cycle write (port 1 has priority), with register 0 optionally forced to zero.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int unsigned DW      = RF_DW,
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic                           active,
  input  logic [AW-1:0]                  addr,
  input  logic [nreg(AW)-1:0][DW-1:0]    regs,
  input  logic                           fwd_en0,
  input  logic [AW-1:0]                  fwd_addr0,
  input  logic [DW-1:0]                  fwd_data0,
  input  logic                           fwd_en1,
  input  logic [AW-1:0]                  fwd_addr1,
  input  logic [DW-1:0]                  fwd_data1,
  output logic [DW-1:0]                  data
);

  always_comb begin
    data = regs[addr];
    if (BYPASS != 0) begin
      if (fwd_en0 && (fwd_addr0 == addr)) data = fwd_data0;
      if (fwd_en1 && (fwd_addr1 == addr)) data = fwd_data1;
    end
    if ((ZERO_R0 != 0) && (addr == '0)) data = '0;
    if (!active) data = '0;
  end

endmodule

// File: rtl/register_file_mp.sv
// Two-write / two-read flop-based register file with write tracking and a
// same-address write-collision pulse.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DW      = RF_DW,
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1
) (
  input logic                Clk,
  input logic                Rst_n,
  register_file_mp_if.slave  bus
);

  localparam int unsigned NREG = nreg(AW);

  logic [NREG-1:0][DW-1:0] regs;
  logic [NREG-1:0]         mask;
  logic                    conflict;
  logic                    store0;
  logic                    store1;
  logic                    fwd0;
  logic                    fwd1;

  // Writes aimed at a hardwired-zero register 0 are dropped entirely.
  assign store0 = bus.WEN0 && !((ZERO_R0 != 0) && (bus.RW0 == '0));
  assign store1 = bus.WEN1 && !((ZERO_R0 != 0) && (bus.RW1 == '0));
  assign fwd0   = bus.WEN0 && Rst_n;
  assign fwd1   = bus.WEN1 && Rst_n;

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      regs     <= '0;
      mask     <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= bus.WEN0 && bus.WEN1 && (bus.RW0 == bus.RW1);
      if (store0) begin
        regs[bus.RW0] <= bus.busW0;
        mask[bus.RW0] <= 1'b1;
      end
      if (store1) begin
        regs[bus.RW1] <= bus.busW1;
        mask[bus.RW1] <= 1'b1;
      end
    end
  end

  assign bus.wr_mask     = mask;
  assign bus.wr_conflict = conflict;

  rf_read_port #(
    .DW(DW), .AW(AW), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
  ) u_read_x (
    .active    (Rst_n),
    .addr      (bus.RX),
    .regs      (regs),
    .fwd_en0   (fwd0),
    .fwd_addr0 (bus.RW0),
    .fwd_data0 (bus.busW0),
    .fwd_en1   (fwd1),
    .fwd_addr1 (bus.RW1),
    .fwd_data1 (bus.busW1),
    .data      (bus.busX)
  );

  rf_read_port #(
    .DW(DW), .AW(AW), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
  ) u_read_y (
    .active    (Rst_n),
    .addr      (bus.RY),
    .regs      (regs),
    .fwd_en0   (fwd0),
    .fwd_addr0 (bus.RW0),
    .fwd_data0 (bus.busW0),
    .fwd_en1   (fwd1),
    .fwd_addr1 (bus.RW1),
    .fwd_data1 (bus.busW1),
    .data      (bus.busY)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: three configurations (bypass, no bypass,
// zero register 0) driven with identical stimulus and compared to an array model.
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wen0, wen1;
  logic [2:0] rw0, rw1, rx, ry;
  logic [7:0] bw0, bw1;

  register_file_mp_if #(.DW(8), .AW(3)) if_b  ();
  register_file_mp_if #(.DW(8), .AW(3)) if_nb ();
  register_file_mp_if #(.DW(8), .AW(3)) if_z  ();

  assign if_b.WEN0  = wen0;  assign if_b.RW0  = rw0;  assign if_b.busW0  = bw0;
  assign if_b.WEN1  = wen1;  assign if_b.RW1  = rw1;  assign if_b.busW1  = bw1;
  assign if_b.RX    = rx;    assign if_b.RY   = ry;
  assign if_nb.WEN0 = wen0;  assign if_nb.RW0 = rw0;  assign if_nb.busW0 = bw0;
  assign if_nb.WEN1 = wen1;  assign if_nb.RW1 = rw1;  assign if_nb.busW1 = bw1;
  assign if_nb.RX   = rx;    assign if_nb.RY  = ry;
  assign if_z.WEN0  = wen0;  assign if_z.RW0  = rw0;  assign if_z.busW0  = bw0;
  assign if_z.WEN1  = wen1;  assign if_z.RW1  = rw1;  assign if_z.busW1  = bw1;
  assign if_z.RX    = rx;    assign if_z.RY   = ry;

  register_file_mp #(.DW(8), .AW(3), .ZERO_R0(0), .BYPASS(1)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .bus(if_b));
  register_file_mp #(.DW(8), .AW(3), .ZERO_R0(0), .BYPASS(0)) dut_nb (
    .Clk(clk), .Rst_n(rst_n), .bus(if_nb));
  register_file_mp #(.DW(8), .AW(3), .ZERO_R0(1), .BYPASS(1)) dut_z (
    .Clk(clk), .Rst_n(rst_n), .bus(if_z));

  // Reference state: plain arrays, one for normal storage, one for the zero-r0 variant.
  logic [7:0] m_reg  [8];
  logic [7:0] mz_reg [8];
  logic [7:0] m_mask, mz_mask;
  logic       m_conf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_read(input bit byp, input bit zr, input logic [2:0] a);
    logic [7:0] v;
    if (!rst_n) return 8'h00;
    v = zr ? mz_reg[a] : m_reg[a];
    if (byp && wen0 && rw0 == a) v = bw0;
    if (byp && wen1 && rw1 == a) v = bw1;
    if (zr && a == 3'd0) v = 8'h00;
    return v;
  endfunction

  task automatic apply(input logic r, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic w1, input logic [2:0] a1, input logic [7:0] d1,
                       input logic [2:0] x, input logic [2:0] y);
    rst_n = r; wen0 = w0; rw0 = a0; bw0 = d0; wen1 = w1; rw1 = a1; bw1 = d1; rx = x; ry = y;
  endtask

  task automatic check_all();
    @(negedge clk);
    check("b.busX",  32'(if_b.busX),  32'(exp_read(1'b1, 1'b0, rx)));
    check("b.busY",  32'(if_b.busY),  32'(exp_read(1'b1, 1'b0, ry)));
    check("nb.busX", 32'(if_nb.busX), 32'(exp_read(1'b0, 1'b0, rx)));
    check("nb.busY", 32'(if_nb.busY), 32'(exp_read(1'b0, 1'b0, ry)));
    check("z.busX",  32'(if_z.busX),  32'(exp_read(1'b1, 1'b1, rx)));
    check("z.busY",  32'(if_z.busY),  32'(exp_read(1'b1, 1'b1, ry)));
    check("b.mask",  32'(if_b.wr_mask),  32'(m_mask));
    check("nb.mask", 32'(if_nb.wr_mask), 32'(m_mask));
    check("z.mask",  32'(if_z.wr_mask),  32'(mz_mask));
    check("b.conf",  32'(if_b.wr_conflict),  32'(m_conf));
    check("nb.conf", 32'(if_nb.wr_conflict), 32'(m_conf));
    check("z.conf",  32'(if_z.wr_conflict),  32'(m_conf));
  endtask

  task automatic clock();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i]  = 8'h00;
        mz_reg[i] = 8'h00;
      end
      m_mask = 8'h00; mz_mask = 8'h00; m_conf = 1'b0;
    end else begin
      m_conf = wen0 && wen1 && (rw0 == rw1);
      if (wen0) begin
        m_reg[rw0] = bw0; m_mask[rw0] = 1'b1;
        if (rw0 != 3'd0) begin mz_reg[rw0] = bw0; mz_mask[rw0] = 1'b1; end
      end
      if (wen1) begin
        m_reg[rw1] = bw1; m_mask[rw1] = 1'b1;
        if (rw1 != 3'd0) begin mz_reg[rw1] = bw1; mz_mask[rw1] = 1'b1; end
      end
    end
    #1;
  endtask

  initial begin
    apply(1'b0, 1'b1, 3'd3, 8'hAA, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin m_reg[i] = 8'h00; mz_reg[i] = 8'h00; end
    m_mask = 8'h00; mz_mask = 8'h00; m_conf = 1'b0;
    #1;

    // Reset held while a write is presented
    apply(1'b0, 1'b1, 3'd3, 8'hAA, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
    check_all();
    check("rst_busX", 32'(if_b.busX), 32'h00);
    check("rst_mask", 32'(if_b.wr_mask), 32'h00);
    clock();

    // Basic write then read
    apply(1'b1, 1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1);
    check_all(); clock();
    apply(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2);
    check_all();
    check("basic_busX", 32'(if_b.busX), 32'h5A);
    check("basic_mask", 32'(if_b.wr_mask), 32'h04);
    clock();

    // Collision on register 5
    apply(1'b1, 1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22, 3'd5, 3'd5);
    check_all();
    check("coll_fwd", 32'(if_b.busX), 32'h22);
    clock();
    apply(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd2);
    check_all();
    check("coll_reg5", 32'(if_nb.busX), 32'h22);
    check("coll_pulse", 32'(if_b.wr_conflict), 32'h1);
    clock();
    apply(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd2);
    check_all();
    check("coll_clear", 32'(if_b.wr_conflict), 32'h0);
    clock();

    // Bypass vs. no bypass on register 6
    apply(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h3C, 3'd1, 3'd6);
    check_all();
    check("byp_same", 32'(if_b.busY), 32'h3C);
    check("nobyp_old", 32'(if_nb.busY), 32'h00);
    clock();
    apply(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd1, 3'd6);
    check_all();
    check("nobyp_next", 32'(if_nb.busY), 32'h3C);
    clock();

    // Zero register: both ports hit address 0
    apply(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 8'hEE, 3'd0, 3'd0);
    check_all();
    check("zero_nofwd", 32'(if_z.busX), 32'h00);
    clock();
    apply(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
    check_all();
    check("zero_read", 32'(if_z.busX), 32'h00);
    check("zero_mask0", 32'(if_z.wr_mask[0]), 32'h0);
    check("zero_conf", 32'(if_z.wr_conflict), 32'h1);
    clock();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      apply(($urandom_range(0, 19) != 0),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      check_all(); clock();
    end

    // Fill every register, then a one-edge reset pulse
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b1, 3'(i), 8'(8'h10 + i), 1'b1, 3'(i + 4), 8'(8'h80 + i), 3'(i), 3'(i + 4));
      check_all(); clock();
    end
    apply(1'b0, 1'b1, 3'd1, 8'h99, 1'b1, 3'd7, 8'h98, 3'd1, 3'd7);
    check_all();
    check("midrst_busX", 32'(if_b.busX), 32'h00);
    clock();
    apply(1'b1, 1'b1, 3'd1, 8'h77, 1'b0, 3'd0, 8'h00, 3'd4, 3'd7);
    check_all();
    check("midrst_clr", 32'(if_b.busX), 32'h00);
    check("midrst_mask", 32'(if_b.wr_mask), 32'h00);
    clock();
    apply(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1);
    check_all();
    check("midrst_wr", 32'(if_nb.busX), 32'h77);
    check("midrst_mask2", 32'(if_b.wr_mask), 32'h02);
    clock();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
